// File: rtl/alu_op_issuer_if.sv
// Request/response and ALU-facing signal bundle for alu_op_issuer.
// The slave side is the issuer; the master side is the control path together with the ALU.
interface alu_op_issuer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic [31:0] alu_first;
    logic [31:0] alu_second;
    logic [3:0]  alu_select;
    logic [31:0] alu_result;
    logic        alu_zero;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    modport master (
        output in_valid, alu_op, funct, op_a, op_b, alu_result, alu_zero, out_ready,
        input  in_ready, alu_first, alu_second, alu_select, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct, op_a, op_b, alu_result, alu_zero, out_ready,
        output in_ready, alu_first, alu_second, alu_select, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues one decoded MIPS ALU operation at a time, waits out the ALU latency and returns result/zero.
// Optional macro ALU_NOR_EN makes R-type funct 100111 (NOR) a legal operation.
module alu_op_issuer #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    alu_op_issuer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

    state_e      state_q,      state_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [31:0] alu_first_q,  alu_first_d;
    logic [31:0] alu_second_q, alu_second_d;
    logic [3:0]  alu_select_q, alu_select_d;
    logic [31:0] result_q,     result_d;
    logic        zero_q,       zero_d;
    logic        illegal_q,    illegal_d;
    logic        out_valid_q,  out_valid_d;

    logic        dec_legal;
    logic [3:0]  dec_sel;
    logic        accept;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_legal = 1'b1;
        dec_sel   = SEL_ADD;
        case (bus.alu_op)
            2'b00: dec_sel = SEL_ADD;
            2'b01: dec_sel = SEL_SUB;
            2'b10: begin
                case (bus.funct)
                    6'b100000: dec_sel = SEL_ADD;
                    6'b100010: dec_sel = SEL_SUB;
                    6'b100100: dec_sel = SEL_AND;
                    6'b100101: dec_sel = SEL_OR;
                    6'b101010: dec_sel = SEL_SLT;
`ifdef ALU_NOR_EN
                    6'b100111: dec_sel = SEL_NOR;
`else
                    6'b100111: dec_legal = 1'b0;
`endif
                    default:   dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign bus.in_ready = (state_q == IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_first_d  = alu_first_q;
        alu_second_d = alu_second_q;
        alu_select_d = alu_select_q;
        result_d     = result_q;
        zero_d       = zero_q;
        illegal_d    = illegal_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_legal) begin
                        alu_first_d  = bus.op_a;
                        alu_second_d = bus.op_b;
                        alu_select_d = dec_sel;
                        cnt_d        = LAT_LOAD;
                        state_d      = ISSUE;
                    end else begin
                        // Undecodable: answer immediately, leave the ALU inputs untouched.
                        result_d    = '0;
                        zero_d      = 1'b0;
                        illegal_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CAPTURE: begin
                result_d    = bus.alu_result;
                zero_d      = bus.alu_zero;
                illegal_d   = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_first_q  <= '0;
            alu_second_q <= '0;
            alu_select_q <= SEL_ADD;
            result_q     <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_first_q  <= alu_first_d;
            alu_second_q <= alu_second_d;
            alu_select_q <= alu_select_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            illegal_q    <= illegal_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.alu_first  = alu_first_q;
    assign bus.alu_second = alu_second_q;
    assign bus.alu_select = alu_select_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.illegal    = illegal_q;
    assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Drives two issuers (ALU_LATENCY 1 and 3) with identical stimulus, each with its own ALU model,
// and compares them against a reference built from the operation mnemonics.
module tb_alu_op_issuer;

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_NOR, K_ILL} kind_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid  = 1'b0;
    logic [1:0]  alu_op    = 2'b00;
    logic [5:0]  funct     = 6'b000000;
    logic [31:0] op_a      = '0;
    logic [31:0] op_b      = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_v  [2];
    logic        out_valid_v [2];
    logic        zero_v      [2];
    logic        illegal_v   [2];
    logic [31:0] result_v    [2];
    logic [31:0] first_v     [2];
    logic [31:0] second_v    [2];
    logic [3:0]  sel_v       [2];

    int checks = 0;
    int errors = 0;
    int lat_of [2] = '{1, 3};

    logic [3:0]  prev_sel;
    logic [31:0] prev_a;
    logic [31:0] prev_b;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel);
        case (sel)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : lane
            localparam int L = (g == 0) ? 1 : 3;
            alu_op_issuer_if bus ();
            alu_op_issuer #(.ALU_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

            logic [31:0] pipe_r [L];
            logic        pipe_z [L];
            always @(posedge clk) begin
                pipe_r[0] <= alu_fn(bus.alu_first, bus.alu_second, bus.alu_select);
                pipe_z[0] <= (bus.alu_first == bus.alu_second);
                for (int k = 1; k < L; k++) begin
                    pipe_r[k] <= pipe_r[k-1];
                    pipe_z[k] <= pipe_z[k-1];
                end
            end

            assign bus.alu_result = pipe_r[L-1];
            assign bus.alu_zero   = pipe_z[L-1];
            assign bus.in_valid   = in_valid;
            assign bus.alu_op     = alu_op;
            assign bus.funct      = funct;
            assign bus.op_a       = op_a;
            assign bus.op_b       = op_b;
            assign bus.out_ready  = out_ready;

            assign in_ready_v[g]  = bus.in_ready;
            assign out_valid_v[g] = bus.out_valid;
            assign zero_v[g]      = bus.zero;
            assign illegal_v[g]   = bus.illegal;
            assign result_v[g]    = bus.result;
            assign first_v[g]     = bus.alu_first;
            assign second_v[g]    = bus.alu_second;
            assign sel_v[g]       = bus.alu_select;
        end
    endgenerate

    function automatic kind_e ref_decode(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return K_ADD;
        if (op == 2'b01) return K_SUB;
        if (op == 2'b11) return K_ILL;
        if (fn == 6'h20) return K_ADD;
        if (fn == 6'h22) return K_SUB;
        if (fn == 6'h24) return K_AND;
        if (fn == 6'h25) return K_OR;
        if (fn == 6'h2a) return K_SLT;
`ifdef ALU_NOR_EN
        if (fn == 6'h27) return K_NOR;
`endif
        return K_ILL;
    endfunction

    function automatic logic [3:0] ref_select(input kind_e k);
        logic [3:0] table_sel [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
        return table_sel[int'(k)];
    endfunction

    function automatic logic [31:0] ref_result(input kind_e k, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        case (k)
            K_ADD:   return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            K_SUB:   return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            K_AND:   return a & b;
            K_OR:    return a | b;
            K_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            K_NOR:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // One operation on both lanes; checks ALU drive, latency and returned values per lane.
    task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b);
        kind_e       k;
        logic        legal;
        logic [3:0]  esel;
        logic [31:0] ea, eb, eres;
        logic        ezero;
        int          seen [2];
        int          lat_exp [2];
        k     = ref_decode(op, fn);
        legal = (k != K_ILL);
        esel  = legal ? ref_select(k) : prev_sel;
        ea    = legal ? a : prev_a;
        eb    = legal ? b : prev_b;
        eres  = legal ? ref_result(k, a, b) : 32'd0;
        ezero = legal ? (a == b) : 1'b0;
        for (int i = 0; i < 2; i++) lat_exp[i] = legal ? lat_of[i] + 2 : 1;
        seen = '{0, 0};

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_before_accept lane%0d: got %b want 1", i, in_ready_v[i]);
            end
        end
        in_valid  = 1'b1;
        alu_op    = op;
        funct     = fn;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b1;
        @(posedge clk);

        for (int cyc = 1; cyc <= 40 && (seen[0] == 0 || seen[1] == 0); cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (seen[i] == 0) begin
                    checks++;
                    if (sel_v[i] !== esel || first_v[i] !== ea || second_v[i] !== eb) begin
                        errors++;
                        $display("FAIL alu_drive lane%0d cyc%0d: sel=%b a=%h b=%h want sel=%b a=%h b=%h",
                                 i, cyc, sel_v[i], first_v[i], second_v[i], esel, ea, eb);
                    end
                    if (out_valid_v[i] === 1'b1) begin
                        seen[i] = cyc;
                        checks++;
                        if (cyc != lat_exp[i] || result_v[i] !== eres || zero_v[i] !== ezero ||
                            illegal_v[i] !== !legal) begin
                            errors++;
                            $display("FAIL response lane%0d op=%b fn=%b: lat=%0d res=%h z=%b ill=%b want lat=%0d res=%h z=%b ill=%b",
                                     i, op, fn, cyc, result_v[i], zero_v[i], illegal_v[i],
                                     lat_exp[i], eres, ezero, !legal);
                        end
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (seen[i] == 0) begin
                checks++;
                errors++;
                $display("FAIL timeout lane%0d: got no out_valid want out_valid within 40 cycles", i);
            end
        end
        if (legal) begin
            prev_sel = esel;
            prev_a   = a;
            prev_b   = b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b0 || out_valid_v[i] !== 1'b0 || sel_v[i] !== 4'b0010 ||
                first_v[i] !== 32'd0 || second_v[i] !== 32'd0 || result_v[i] !== 32'd0 ||
                zero_v[i] !== 1'b0 || illegal_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state lane%0d: rdy=%b ov=%b sel=%b a=%h b=%h res=%h z=%b ill=%b want 0 0 0010 0 0 0 0 0",
                         i, in_ready_v[i], out_valid_v[i], sel_v[i], first_v[i], second_v[i],
                         result_v[i], zero_v[i], illegal_v[i]);
            end
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset lane%0d: got %b want 1", i, in_ready_v[i]);
            end
        end
        prev_sel = 4'b0010;
        prev_a   = '0;
        prev_b   = '0;
    endtask

    task automatic test_add();
        run_op(2'b00, 6'b000000, 32'd5, 32'd7);
    endtask

    task automatic test_branch_compare();
        run_op(2'b01, 6'b000000, 32'h1234, 32'h1234);
    endtask

    task automatic test_slt();
        run_op(2'b10, 6'b101010, 32'd2, 32'd9);
        run_op(2'b10, 6'b101010, 32'hFFFF_FFFE, 32'd3);
    endtask

    task automatic test_illegal();
        run_op(2'b11, 6'b100000, 32'd11, 32'd22);
        run_op(2'b10, 6'b000011, 32'd1, 32'd1);
    endtask

    task automatic test_nor();
        run_op(2'b10, 6'b100111, 32'h0F0F_0000, 32'h0000_00F0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] legal_fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [5:0]  fn;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 3) != 0) ? legal_fn[$urandom_range(0, 5)] : 6'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(op, fn, a, b);
        end
    endtask

    task automatic test_backpressure_reset();
        int got [2];
        @(negedge clk);
        in_valid  = 1'b1;
        alu_op    = 2'b00;
        op_a      = 32'd100;
        op_b      = 32'd23;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Different request kept pending while busy; it must not be taken.
        alu_op = 2'b01;
        op_a   = 32'd9;
        op_b   = 32'd4;
        repeat (6) @(negedge clk);
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (out_valid_v[i] !== 1'b1 || result_v[i] !== 32'd123 || in_ready_v[i] !== 1'b0 ||
                    illegal_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_hold lane%0d: ov=%b res=%h rdy=%b ill=%b want 1 0000007b 0 0",
                             i, out_valid_v[i], result_v[i], in_ready_v[i], illegal_v[i]);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid_v[i] !== 1'b0 || in_ready_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL retire lane%0d: ov=%b rdy=%b want 0 1", i, out_valid_v[i], in_ready_v[i]);
            end
        end

        in_valid = 1'b1;
        alu_op   = 2'b00;
        op_a     = 32'd1;
        op_b     = 32'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid_v[i] !== 1'b0 || in_ready_v[i] !== 1'b0 || sel_v[i] !== 4'b0010 ||
                first_v[i] !== 32'd0 || result_v[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_issue lane%0d: ov=%b rdy=%b sel=%b a=%h res=%h want 0 0 0010 0 0",
                         i, out_valid_v[i], in_ready_v[i], sel_v[i], first_v[i], result_v[i]);
            end
        end
        rst = 1'b0;
        #1;
        got = '{0, 0};
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_mid_reset lane%0d: got %b want 1", i, in_ready_v[i]);
            end
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (out_valid_v[i] === 1'b1) got[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] != 0) begin
                errors++;
                $display("FAIL discarded_op lane%0d: out_valid seen %0d cycles want 0", i, got[i]);
            end
        end
        prev_sel = 4'b0010;
        prev_a   = '0;
        prev_b   = '0;
        run_op(2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF);
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch_compare();
        test_slt();
        test_illegal();
        test_nor();
        test_back_to_back();
        test_backpressure_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Issuing end of the 32-bit ALU interface in the MIPS datapath.
- Accepts one operation per handshake: ALUOp, funct and two operands.
- Decodes the operation into the ALU's 4-bit select code, drives the ALU, waits out the ALU's registered latency, then captures the result and the zero flag.
- Returns result/zero to the multi-cycle control path over a valid/ready handshake.

Parameters:
ALU_LATENCY, 1, number of clock edges between operands/select becoming stable and the ALU's registered output being valid (legal range 1..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
alu_op  input  2  MIPS ALUOp: 00 add, 01 subtract, 10 R-type (use funct), 11 reserved
funct  input  6  R-type funct field
op_a  input  32  first operand
op_b  input  32  second operand
alu_first  output  32  to ALU first operand
alu_second  output  32  to ALU second operand
alu_select  output  4  to ALU select
alu_result  input  32  registered ALU output
alu_zero  input  1  ALU zero flag (first == second)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  32  captured ALU result
zero  output  1  captured zero flag
illegal  output  1  operation was undecodable; result is 0

Behaviour:
- Reset (rst=1 at an edge) sets the following; any in-flight operation is discarded with no output:
  - state IDLE
  - alu_first=0, alu_second=0, alu_select=4'b0010
  - result=0, zero=0, illegal=0, out_valid=0
- in_ready = (state==IDLE) && !rst. Combinational; no other input affects it.
- Accept: an edge with in_valid && in_ready latches op_a, op_b and the decoded select into alu_first, alu_second and alu_select.
- Decode:
  - ALUOp 00 -> 0010; ALUOp 01 -> 0110.
  - ALUOp 10 with funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100 (see Optional Feature).
  - ALUOp 11, or any other funct, is illegal.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
  - IDLE -> ISSUE on a legal accept.
  - IDLE -> DONE on an illegal accept: illegal=1, result=0, zero=0. alu_* outputs are left unchanged; the ALU is not issued.
  - ISSUE: held for exactly ALU_LATENCY cycles, counted by a 4-bit counter loaded at accept. alu_first, alu_second and alu_select are stable for the whole state. Then -> CAPTURE.
  - CAPTURE: one cycle. At its closing edge: result <= alu_result, zero <= alu_zero, illegal <= 0, out_valid <= 1. Then -> DONE.
  - DONE: out_valid=1, and result/zero/illegal are held until an edge with out_ready=1. That edge clears out_valid and returns to IDLE.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - legal operation: ALU_LATENCY+2 cycles (3 at default);
  - illegal operation: 1 cycle.
- Back-to-back: one operation in flight; no pipelining. After the retire edge the next accept is at the earliest the following edge, since in_ready rises in the IDLE cycle.
- out_ready sampled outside DONE is ignored. in_valid outside IDLE is ignored; the request stays pending upstream.
- Arithmetic is done entirely by the ALU; alu_result is passed through unmodified at 32 bits, including SLT.
- rst has priority over every handshake at the same edge.

Optional Feature:
- Macro: ALU_NOR_EN.
- Defined: ALUOp 10 with funct 100111 decodes to select 4'b1100 and is issued like any other legal operation.
- Not defined: funct 100111 is illegal. It takes the IDLE -> DONE path, illegal=1, result=0, and select 1100 is never driven.

Test Plan:
1. Add: after reset, alu_op=00, op_a=5, op_b=7, ALU model returns the sum -> alu_select=0010 throughout ISSUE; out_valid on the 3rd cycle after accept; result=12, zero=0, illegal=0.
2. Branch compare: alu_op=01, op_a=op_b=0x1234 -> select 0110; result=0, zero=1.
3. R-type SLT with ALU_LATENCY=3: funct=101010, op_a=2, op_b=9 -> ISSUE lasts 3 cycles; out_valid 5 cycles after accept; result=1.
4. Illegal op: alu_op=11 -> out_valid 1 cycle after accept; illegal=1, result=0; alu_select keeps its previous value.
5. Backpressure and reset: hold out_ready=0 for 4 cycles in DONE -> result and out_valid stable, in_ready=0. Then assert rst during a new ISSUE -> next cycle state IDLE, out_valid=0, in_ready=1 after rst drops.
6. NOR: funct=100111 -> with ALU_NOR_EN, select 1100 and the ALU model's value is returned; without it, illegal=1.
